ifresp: RTL and testbench

Memory-side responder for the CPU system-interface handshake: grants the interface (zw) to a pending request (zg), executes one or more read/write transactions against an internal word memory, and answers each with a timed rok (accepted) or ren (rejected) pulse. It is the far end of the CPU interface control and is the bench/behavioural memory module for the system model. A mute input suppresses answers so the CPU's no-answer alarm path can be exercised.

---
 rtl/ifresp.sv | 195 +++++++++++++++++++
 tb/tb_ifresp.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifresp.sv
// ifresp: memory-side responder for the CPU system-interface handshake (grant, access, timed rok/ren answer).
// Define IFRESP_WPROT_EN to reject writes below PROT_LIMIT; without it every in-range write is accepted.
module ifresp #(
    parameter int          AW         = 12,
    parameter int          WAIT_TICKS = 3,
    parameter int          RESP_TICKS = 2,
    parameter logic [15:0] PROT_LIMIT = 16'h0100
) (
    input  logic        clk_sys,
    input  logic        clo_n,
    input  logic        zg,
    input  logic        r,
    input  logic        w,
    input  logic [15:0] ad,
    input  logic [15:0] di,
    input  logic        mute,
    output logic        zw,
    output logic        rok,
    output logic        ren,
    output logic [15:0] dout,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GRANT  = 3'd1,
        S_ACCESS = 3'd2,
        S_RESP   = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    localparam logic [15:0] WAIT_LOAD = 16'(WAIT_TICKS - 1);
    localparam logic [15:0] RESP_LOAD = 16'(RESP_TICKS - 1);
    localparam logic [16:0] MEM_WORDS = 17'd1 << AW;
    localparam int          MEM_DEPTH = 1 << AW;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] ad_q, ad_d;
    logic [15:0] di_q, di_d;
    logic [15:0] dout_q, dout_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        zw_q, zw_d;
    logic        rok_q, rok_d;
    logic        ren_q, ren_d;
    logic        busy_q, busy_d;

    logic        mem_we_s;
    logic        in_range_s;
    logic        prot_s;
    logic        accept_s;
    logic [15:0] mem_rdata_s;

    logic [15:0] mem_q [0:MEM_DEPTH-1];

    assign in_range_s  = ({1'b0, ad_q} < MEM_WORDS);
    assign mem_rdata_s = mem_q[ad_q[AW-1:0]];

`ifdef IFRESP_WPROT_EN
    assign prot_s = wr_q & (ad_q < PROT_LIMIT);
`else
    logic unused_prot_s;
    assign prot_s        = 1'b0;
    assign unused_prot_s = ^PROT_LIMIT;
`endif

    // A simultaneous read+write command is malformed and always rejected.
    assign accept_s = ~(rd_q & wr_q) & in_range_s & ~prot_s;

    // Next-state and next-output logic for the handshake FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ad_d     = ad_q;
        di_d     = di_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        dout_d   = dout_q;
        rok_d    = 1'b0;
        ren_d    = 1'b0;
        mem_we_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (zg) begin
                    state_d = S_GRANT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                if (!zg) begin
                    state_d = S_IDLE;
                end else if ((r | w) && !mute) begin
                    ad_d    = ad;
                    di_d    = di;
                    rd_d    = r;
                    wr_d    = w;
                    cnt_d   = WAIT_LOAD;
                    state_d = S_ACCESS;
                end else begin
                    state_d = S_GRANT;
                end
            end
            S_ACCESS: begin
                if (!zg) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 16'd0) begin
                    rok_d    = accept_s;
                    ren_d    = ~accept_s;
                    mem_we_s = accept_s & wr_q;
                    if (accept_s && rd_q) begin
                        dout_d = mem_rdata_s;
                    end else begin
                        dout_d = dout_q;
                    end
                    cnt_d   = RESP_LOAD;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_RESP: begin
                if (!zg) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 16'd0) begin
                    state_d = S_DRAIN;
                end else begin
                    rok_d = rok_q;
                    ren_d = ren_q;
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DRAIN: begin
                // A command still held from the last transaction must not retrigger.
                if (!zg) begin
                    state_d = S_IDLE;
                end else if (!r && !w) begin
                    state_d = S_GRANT;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // zw trails entry into GRANT by one cycle but drops together with the return to IDLE.
        zw_d   = (state_q != S_IDLE) && (state_d != S_IDLE);
        busy_d = (state_d != S_IDLE);
    end

    // State, latched command and registered outputs.
    always_ff @(posedge clk_sys or negedge clo_n) begin
        if (!clo_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            ad_q    <= 16'd0;
            di_q    <= 16'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            dout_q  <= 16'd0;
            zw_q    <= 1'b0;
            rok_q   <= 1'b0;
            ren_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ad_q    <= ad_d;
            di_q    <= di_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            dout_q  <= dout_d;
            zw_q    <= zw_d;
            rok_q   <= rok_d;
            ren_q   <= ren_d;
            busy_q  <= busy_d;
        end
    end

    // Word memory; contents survive reset.
    always_ff @(posedge clk_sys) begin
        if (mem_we_s) begin
            mem_q[ad_q[AW-1:0]] <= di_q;
        end
    end

    assign zw   = zw_q;
    assign rok  = rok_q;
    assign ren  = ren_q;
    assign dout = dout_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_ifresp.sv
// Self-checking bench for ifresp: scoreboard of expected answers built from a small memory model.
module tb_ifresp;
    localparam int          AW = 12;
    localparam int          WT = 3;
    localparam int          RT = 2;
    localparam logic [15:0] PL = 16'h0100;

    logic        clk_sys = 1'b0;
    logic        clo_n   = 1'b0;
    logic        zg = 1'b0, r = 1'b0, w = 1'b0, mute = 1'b0;
    logic [15:0] ad = 16'h0, di = 16'h0;
    logic        zw, rok, ren, busy;
    logic [15:0] dout;

    ifresp #(.AW(AW), .WAIT_TICKS(WT), .RESP_TICKS(RT), .PROT_LIMIT(PL)) dut (
        .clk_sys(clk_sys), .clo_n(clo_n), .zg(zg), .r(r), .w(w), .ad(ad), .di(di),
        .mute(mute), .zw(zw), .rok(rok), .ren(ren), .dout(dout), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        ok;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mem_m [logic [15:0]];
    logic [15:0] exp_dout = 16'h0;
    int          checks = 0;
    int          errors = 0;

    logic        got_ok, got_ren, zw_drop, both_hi;
    int          lat, wid;
    logic [15:0] dseen;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic void model_push(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        logic prot;
`ifdef IFRESP_WPROT_EN
        prot = wr && (a < PL);
`else
        prot = 1'b0;
`endif
        e.ok = !(rd && wr) && (32'(a) < (32'd1 << AW)) && !prot;
        if (e.ok && wr) mem_m[a] = d;
        if (e.ok && rd) exp_dout = mem_m.exists(a) ? mem_m[a] : 16'hxxxx;
        e.data = exp_dout;
        sb.push_back(e);
    endfunction

    // Drives one command in GRANT and measures the answer; leaves r/w held.
    task automatic issue(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        r = rd; w = wr; ad = a; di = d;
        got_ok = 1'b0; got_ren = 1'b0; zw_drop = 1'b0; both_hi = 1'b0; lat = 0; wid = 0; dseen = 16'h0;
        tick();
        while (!(rok || ren) && lat < 20) begin
            if (zw !== 1'b1) zw_drop = 1'b1;
            tick();
            lat++;
        end
        while ((rok || ren) && wid < 20) begin
            if (zw !== 1'b1) zw_drop = 1'b1;
            if (rok && ren) both_hi = 1'b1;
            got_ok  = got_ok | rok;
            got_ren = got_ren | ren;
            if (rok) dseen = dout;
            tick();
            wid++;
        end
        if (!got_ok) dseen = dout;
    endtask

    task automatic open_if();
        zg = 1'b1;
        tick();
    endtask

    task automatic close_if();
        r = 1'b0; w = 1'b0; zg = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        clo_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({zw, rok, ren, busy, dout} !== 20'h0) begin
            errors++; $display("FAIL reset_hold: zw/rok/ren/busy/dout=%b%b%b%b %h want all 0", zw, rok, ren, busy, dout);
        end
        clo_n = 1'b1;
        tick();
        checks++;
        if ({zw, rok, ren, busy, dout} !== 20'h0) begin
            errors++; $display("FAIL reset_idle: zw/rok/ren/busy/dout=%b%b%b%b %h want all 0", zw, rok, ren, busy, dout);
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        model_push(1'b0, 1'b1, 16'h0200, 16'hBEEF);
        open_if();
        checks++;
        if (zw !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL grant_lag: zw=%b busy=%b want zw=0 busy=1", zw, busy);
        end
        issue(1'b0, 1'b1, 16'h0200, 16'hBEEF);
        e = sb.pop_front();
        checks++;
        if ({got_ok, got_ren} !== {e.ok, ~e.ok}) begin
            errors++; $display("FAIL wr_resp: rok/ren=%b%b want %b%b", got_ok, got_ren, e.ok, ~e.ok);
        end
        checks++;
        if (lat !== WT || wid !== RT || zw_drop || both_hi) begin
            errors++; $display("FAIL wr_timing: lat=%0d width=%0d zwdrop=%b both=%b want lat=%0d width=%0d", lat, wid, zw_drop, both_hi, WT, RT);
        end
        close_if();
        model_push(1'b1, 1'b0, 16'h0200, 16'h0);
        open_if();
        issue(1'b1, 1'b0, 16'h0200, 16'h0);
        e = sb.pop_front();
        checks++;
        if ({got_ok, got_ren} !== {e.ok, ~e.ok}) begin
            errors++; $display("FAIL rd_resp: rok/ren=%b%b want %b%b", got_ok, got_ren, e.ok, ~e.ok);
        end
        checks++;
        if (lat !== WT || wid !== RT || zw_drop || both_hi) begin
            errors++; $display("FAIL rd_timing: lat=%0d width=%0d zwdrop=%b both=%b want lat=%0d width=%0d", lat, wid, zw_drop, both_hi, WT, RT);
        end
        checks++;
        if (dseen !== e.data) begin
            errors++; $display("FAIL rd_data: dout=%h want %h", dseen, e.data);
        end
        close_if();
        checks++;
        if (zw !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL release_idle: zw=%b busy=%b want 0 0", zw, busy);
        end
    endtask

    task automatic test_reject();
        exp_t e;
        model_push(1'b1, 1'b0, 16'h1000, 16'h0);
        open_if();
        issue(1'b1, 1'b0, 16'h1000, 16'h0);
        e = sb.pop_front();
        checks++;
        if ({got_ok, got_ren} !== {e.ok, ~e.ok} || wid !== RT || lat !== WT) begin
            errors++; $display("FAIL oor_resp: rok/ren=%b%b lat=%0d width=%0d want %b%b lat=%0d width=%0d", got_ok, got_ren, lat, wid, e.ok, ~e.ok, WT, RT);
        end
        checks++;
        if (dseen !== e.data) begin
            errors++; $display("FAIL oor_dout: dout=%h want %h", dseen, e.data);
        end
        close_if();
        model_push(1'b1, 1'b1, 16'h0000, 16'h1111);
        open_if();
        issue(1'b1, 1'b1, 16'h0000, 16'h1111);
        e = sb.pop_front();
        checks++;
        if ({got_ok, got_ren} !== {e.ok, ~e.ok} || wid !== RT || both_hi) begin
            errors++; $display("FAIL rw_resp: rok/ren=%b%b width=%0d want %b%b width=%0d", got_ok, got_ren, wid, e.ok, ~e.ok, RT);
        end
        checks++;
        if (dseen !== e.data) begin
            errors++; $display("FAIL rw_dout: dout=%h want %h", dseen, e.data);
        end
        close_if();
    endtask

    task automatic test_atomic();
        exp_t e;
        logic any_resp, drop;
        any_resp = 1'b0; drop = 1'b0;
        model_push(1'b1, 1'b0, 16'h0200, 16'h0);
        open_if();
        issue(1'b1, 1'b0, 16'h0200, 16'h0);
        e = sb.pop_front();
        checks++;
        if (!got_ok || got_ren || dseen !== e.data || zw_drop) begin
            errors++; $display("FAIL atom_rd: rok/ren=%b%b dout=%h zwdrop=%b want 10 %h 0", got_ok, got_ren, dseen, zw_drop, e.data);
        end
        repeat (4) begin
            tick();
            if (rok || ren) any_resp = 1'b1;
            if (zw !== 1'b1) drop = 1'b1;
        end
        checks++;
        if (any_resp || drop || busy !== 1'b1) begin
            errors++; $display("FAIL atom_drain_hold: resp=%b zwdrop=%b busy=%b want 0 0 1", any_resp, drop, busy);
        end
        r = 1'b0;
        tick();
        checks++;
        if (zw !== 1'b1) begin
            errors++; $display("FAIL atom_regrant: zw=%b want 1", zw);
        end
        model_push(1'b0, 1'b1, 16'h0210, 16'h5A5A);
        issue(1'b0, 1'b1, 16'h0210, 16'h5A5A);
        e = sb.pop_front();
        checks++;
        if ({got_ok, got_ren} !== {e.ok, ~e.ok} || lat !== WT || wid !== RT || zw_drop) begin
            errors++; $display("FAIL atom_wr: rok/ren=%b%b lat=%0d width=%0d zwdrop=%b want %b%b %0d %0d 0", got_ok, got_ren, lat, wid, zw_drop, e.ok, ~e.ok, WT, RT);
        end
        close_if();
    endtask

    task automatic test_abort();
        exp_t e;
        logic any_resp;
        any_resp = 1'b0;
        model_push(1'b0, 1'b1, 16'h0300, 16'h1234);
        open_if();
        issue(1'b0, 1'b1, 16'h0300, 16'h1234);
        e = sb.pop_front();
        checks++;
        if ({got_ok, got_ren} !== {e.ok, ~e.ok}) begin
            errors++; $display("FAIL abort_setup: rok/ren=%b%b want %b%b", got_ok, got_ren, e.ok, ~e.ok);
        end
        close_if();
        open_if();
        w = 1'b1; ad = 16'h0300; di = 16'hDEAD;
        tick();
        tick();
        zg = 1'b0; w = 1'b0;
        tick();
        checks++;
        if ({zw, rok, ren, busy} !== 4'b0000) begin
            errors++; $display("FAIL abort_idle: zw/rok/ren/busy=%b%b%b%b want 0000", zw, rok, ren, busy);
        end
        repeat (6) begin
            tick();
            if (rok || ren) any_resp = 1'b1;
        end
        checks++;
        if (any_resp) begin
            errors++; $display("FAIL abort_noresp: answer seen=%b want 0", any_resp);
        end
        model_push(1'b1, 1'b0, 16'h0300, 16'h0);
        open_if();
        issue(1'b1, 1'b0, 16'h0300, 16'h0);
        e = sb.pop_front();
        checks++;
        if (!got_ok || dseen !== e.data) begin
            errors++; $display("FAIL abort_readback: rok=%b dout=%h want 1 %h", got_ok, dseen, e.data);
        end
        close_if();
    endtask

    task automatic test_wprot();
        exp_t e;
        model_push(1'b0, 1'b1, 16'h0010, 16'hCAFE);
        open_if();
        issue(1'b0, 1'b1, 16'h0010, 16'hCAFE);
        e = sb.pop_front();
        checks++;
        if ({got_ok, got_ren} !== {e.ok, ~e.ok} || wid !== RT) begin
            errors++; $display("FAIL wprot_resp: rok/ren=%b%b width=%0d want %b%b width=%0d", got_ok, got_ren, wid, e.ok, ~e.ok, RT);
        end
        close_if();
`ifndef IFRESP_WPROT_EN
        model_push(1'b1, 1'b0, 16'h0010, 16'h0);
        open_if();
        issue(1'b1, 1'b0, 16'h0010, 16'h0);
        e = sb.pop_front();
        checks++;
        if (!got_ok || dseen !== e.data) begin
            errors++; $display("FAIL wprot_readback: rok=%b dout=%h want 1 %h", got_ok, dseen, e.data);
        end
        close_if();
`endif
    endtask

    task automatic test_mute();
        logic any_resp;
        any_resp = 1'b0;
        mute = 1'b1; zg = 1'b1; r = 1'b1; ad = 16'h0200;
        repeat (12) begin
            tick();
            if (rok || ren) any_resp = 1'b1;
        end
        checks++;
        if (zw !== 1'b1 || any_resp) begin
            errors++; $display("FAIL mute_hold: zw=%b resp=%b want zw=1 resp=0", zw, any_resp);
        end
        zg = 1'b0; r = 1'b0;
        tick();
        checks++;
        if (zw !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mute_release: zw=%b busy=%b want 0 0", zw, busy);
        end
        mute = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int n;
        n = 0;
        open_if();
        r = 1'b1; ad = 16'h0200;
        tick();
        while (!rok && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (rok !== 1'b1) begin
            errors++; $display("FAIL rstmid_reach: rok=%b after %0d cycles want 1", rok, n);
        end
        clo_n = 1'b0;
        #1;
        checks++;
        if ({zw, rok, ren, busy, dout} !== 20'h0) begin
            errors++; $display("FAIL rstmid_outputs: zw/rok/ren/busy/dout=%b%b%b%b %h want all 0", zw, rok, ren, busy, dout);
        end
        exp_dout = 16'h0;
        zg = 1'b0; r = 1'b0;
        tick();
        clo_n = 1'b1;
        tick();
        open_if();
        w = 1'b1; ad = 16'h0300; di = 16'hDEAD;
        tick();
        tick();
        clo_n = 1'b0;
        tick();
        zg = 1'b0; w = 1'b0; clo_n = 1'b1;
        tick();
        model_push(1'b1, 1'b0, 16'h0300, 16'h0);
        open_if();
        issue(1'b1, 1'b0, 16'h0300, 16'h0);
        e = sb.pop_front();
        checks++;
        if (!got_ok || dseen !== e.data || lat !== WT) begin
            errors++; $display("FAIL rstmid_readback: rok=%b dout=%h lat=%0d want 1 %h %0d", got_ok, dseen, lat, e.data, WT);
        end
        close_if();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reject();
        test_atomic();
        test_abort();
        test_wprot();
        test_mute();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
